sfr_timers: RTL and testbench
=============================

Name: sfr_timers

Overview:
- Next-generation per-tile special function register block with N independent timer channels. Each channel has a prescaler, a programmable period, one-shot or periodic mode, and a sticky, maskable interrupt-pending bit.
- Keeps the existing tile control functions: software core reset, IRQ enable vector, software-generated interrupt (SGI), IDCODE and CORENUM.
- Sits on the tile's MemSplit32 slave port next to the core. Drives core reset and the interrupt inputs of the core IRQ controller.

Parameters:
- CORENUM, 0, value returned at CORENUM register
- SW_RESET_DEFAULT, 0, reset value of the sw_reset bit
- IRQ_NUM_POW, 4, log2 of the IRQ line count
- TIMER_NUM, 4, number of timer channels, legal range 1..8
- TIMER_WIDTH, 32, counter/period width, legal range 8..32
- PRESC_WIDTH, 8, prescaler width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- host  MemSplit32.Slave  -  register bus
- sw_reset_enb_i  in  1  external sw_reset load strobe
- sw_reset_set_i  in  1  value loaded into sw_reset
- sw_reset_autoclr_i  in  1  value loaded into autoclr
- core_reset_o  out  1  registered rst_i | sw_reset
- irq_en_bo  out  2**IRQ_NUM_POW  IRQ enable vector
- timer_irq_bo  out  TIMER_NUM  per-channel pending & mask
- irq_timer_o  out  1  OR of timer_irq_bo
- sgi_req_o  out  1  one-cycle SGI pulse
- sgi_code_bo  out  IRQ_NUM_POW  SGI code

Behaviour:
- Reset:
  - All state clears asynchronously on rst_i.
  - core_reset_o=1, sw_reset=SW_RESET_DEFAULT; every other output and register resets to 0.
- Bus:
  - host.ack = host.req (combinational).
  - Writes take effect on the next edge and produce no resp.
  - Reads: resp=1 and rdata valid exactly one cycle after req. Unmapped reads return 0; unmapped writes are ignored.
- Address decode uses addr[7:0]:
  - 00 IDCODE = 0xDEADBEEF, read-only.
  - 04 CTRL: bit0 sw_reset, bit1 autoclr.
  - 08 CORENUM, read-only.
  - 0C TIMER_NUM, read-only.
  - 10 IRQ_EN.
  - 14 SGI: a write pulses sgi_req_o for one cycle and latches wdata[IRQ_NUM_POW-1:0].
  - 18 TSTAT: pending bits, write-1-to-clear.
  - 1C TMASK.
  - Channel k at 0x40+0x10*k: +0 TCTRL (bit0 enable, bit1 reload), +4 PERIOD, +8 VALUE (r/w), +C PRESC.
- sw_reset:
  - External strobe loads sw_reset and autoclr.
  - If sw_reset and autoclr are both set, sw_reset clears on the next cycle.
  - A bus write to CTRL has priority over the external strobe.
- While core_reset_o=1: all channel state, TSTAT and TMASK clear synchronously. This overrides bus writes.
- Channel operation, when enabled:
  - presc_cnt counts 0..PRESC. A tick fires when presc_cnt==PRESC; presc_cnt then returns to 0. PRESC=0 gives a tick every cycle.
  - On a tick, if value+1==PERIOD: expiry. value<=0, pending[k]<=1, enable<=reload. Otherwise value<=value+1, truncated to TIMER_WIDTH.
  - PERIOD=0: no expiry; value wraps modulo 2**TIMER_WIDTH.
  - Expiry latency: (PERIOD)*(PRESC+1) cycles from the enable write edge.
- Writes to a channel:
  - TCTRL write clears value and presc_cnt. Host wins over a same-cycle expiry for enable and value.
  - VALUE write loads value and clears presc_cnt.
  - PERIOD and PRESC writes apply at the next tick comparison.
- Disabled channel: holds value and presc_cnt.
- Pending:
  - Sticky until cleared by W1C.
  - A set in the same cycle as a W1C clear wins (stays 1).
- Outputs: timer_irq_bo = pending & mask, registered. irq_timer_o is the OR of the registered timer_irq_bo, so it has no extra cycle of delay.
- Read data: registers narrower than 32 bits are zero-extended.

Decomposition:
- sfr_timers_pkg holds:
  - address localparams and the channel base/stride
  - IDCODE constant
  - TCTRL bit indices
- One sub-module, sfr_timer_ch, per channel, instantiated by generate. It contains the enable/reload/period/value/prescaler state, tick/expiry logic, and the pending set pulse output.
- The top level holds decode, read mux, TSTAT/TMASK, reset and SGI logic.

Test Plan:
- Reset: assert rst_i with no clock edge -> core_reset_o=1 and all outputs 0 immediately. Read 0x00 -> 0xDEADBEEF one cycle later; read 0x0C -> 4.
- Periodic: ch0 PERIOD=5, PRESC=0, TCTRL=3, TMASK=1 -> pending set 5 cycles after the write and every 5 thereafter; irq_timer_o=1. W1C 0x18=1 -> cleared.
- One-shot with prescaler: ch2 PERIOD=3, PRESC=2, TCTRL=1 -> expiry after 9 cycles. enable reads back 0; value holds 0.
- Simultaneous events: W1C on the exact expiry cycle -> pending remains 1. TCTRL write on the expiry cycle -> value=0 and enable follows wdata.
- Wrap/mask: TIMER_WIDTH=8, PERIOD=0 -> value wraps 255->0 with no pending. An expiry with mask=0 -> TSTAT bit set, timer_irq_bo=0.
- Reset mid-run: CTRL write 3 while timers run -> core_reset_o high for one cycle; channels, TSTAT and TMASK cleared; sw_reset auto-clears. SGI write 0x7 -> sgi_req_o one-cycle pulse, sgi_code_bo=7.

Source files
------------

// File: rtl/sfr_timers_pkg.sv
// Shared constants for the sfr_timers tile register block: register map,
// channel window layout, IDCODE value and TCTRL bit positions.
package sfr_timers_pkg;

    // Byte addresses of the tile control registers (decoded on addr[7:0]).
    localparam logic [7:0] ADDR_IDCODE    = 8'h00;
    localparam logic [7:0] ADDR_CTRL      = 8'h04;
    localparam logic [7:0] ADDR_CORENUM   = 8'h08;
    localparam logic [7:0] ADDR_TIMER_NUM = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_EN    = 8'h10;
    localparam logic [7:0] ADDR_SGI       = 8'h14;
    localparam logic [7:0] ADDR_TSTAT     = 8'h18;
    localparam logic [7:0] ADDR_TMASK     = 8'h1C;

    // Channel k lives at CH_BASE + CH_STRIDE*k, four word registers each.
    localparam logic [7:0] CH_BASE   = 8'h40;
    localparam logic [7:0] CH_STRIDE = 8'h10;

    // Word (addr[7:2]) views of the map, used by the decoder.
    localparam logic [5:0] W_IDCODE    = ADDR_IDCODE[7:2];
    localparam logic [5:0] W_CTRL      = ADDR_CTRL[7:2];
    localparam logic [5:0] W_CORENUM   = ADDR_CORENUM[7:2];
    localparam logic [5:0] W_TIMER_NUM = ADDR_TIMER_NUM[7:2];
    localparam logic [5:0] W_IRQ_EN    = ADDR_IRQ_EN[7:2];
    localparam logic [5:0] W_SGI       = ADDR_SGI[7:2];
    localparam logic [5:0] W_TSTAT     = ADDR_TSTAT[7:2];
    localparam logic [5:0] W_TMASK     = ADDR_TMASK[7:2];
    localparam logic [5:0] W_CH_BASE   = CH_BASE[7:2];

    localparam logic [31:0] IDCODE = 32'hDEADBEEF;

    // TCTRL bit positions.
    localparam int unsigned TCTRL_EN_BIT     = 0;
    localparam int unsigned TCTRL_RELOAD_BIT = 1;

    // Register select inside one channel window.
    typedef enum logic [1:0] {
        CH_TCTRL  = 2'd0,
        CH_PERIOD = 2'd1,
        CH_VALUE  = 2'd2,
        CH_PRESC  = 2'd3
    } ch_reg_e;

endpackage

// File: rtl/memsplit32.sv
// MemSplit32 register bus. Handshake: the master holds req (with we, addr,
// wdata) for one cycle; ack answers combinationally in the same cycle; a read
// returns resp=1 with rdata exactly one cycle after req, a write returns no resp.
interface MemSplit32;
    logic        req;
    logic        ack;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;

    modport Master (output req, we, addr, wdata, input ack, resp, rdata);
    modport Slave  (input req, we, addr, wdata, output ack, resp, rdata);
endinterface

// File: rtl/sfr_timer_ch.sv
// One timer channel: prescaler, period compare, one-shot/periodic reload,
// and a single-cycle pulse that sets the channel's pending bit on expiry.
module sfr_timer_ch
    import sfr_timers_pkg::*;
#(
    parameter int unsigned TIMER_WIDTH = 32,
    parameter int unsigned PRESC_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   wr_i,
    input  ch_reg_e                sel_i,
    input  logic [31:0]            wdata_i,
    output logic                   enable_o,
    output logic                   reload_o,
    output logic [TIMER_WIDTH-1:0] period_o,
    output logic [TIMER_WIDTH-1:0] value_o,
    output logic [PRESC_WIDTH-1:0] presc_o,
    output logic                   pending_set_o
);

    localparam logic [TIMER_WIDTH-1:0] ONE_T = 1;
    localparam logic [PRESC_WIDTH-1:0] ONE_P = 1;

    logic                   enable_q, enable_d;
    logic                   reload_q, reload_d;
    logic [TIMER_WIDTH-1:0] period_q, period_d;
    logic [TIMER_WIDTH-1:0] value_q, value_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [PRESC_WIDTH-1:0] presc_cnt_q, presc_cnt_d;
    logic [TIMER_WIDTH-1:0] value_inc;
    logic                   tick;
    logic                   expiry;
    logic                   unused_wdata;

    assign unused_wdata = ^wdata_i;

    // Tick/expiry detection; PERIOD=0 never expires so the counter free-runs.
    always_comb begin
        value_inc = value_q + ONE_T;
        tick      = enable_q && (presc_cnt_q == presc_q);
        expiry    = tick && (period_q != '0) && (value_inc == period_q);
    end

    // Next state: counting first, host writes override it, core reset overrides all.
    always_comb begin
        enable_d    = enable_q;
        reload_d    = reload_q;
        period_d    = period_q;
        value_d     = value_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;

        if (enable_q) begin
            if (tick) begin
                presc_cnt_d = '0;
                if (expiry) begin
                    value_d  = '0;
                    enable_d = reload_q;
                end else begin
                    value_d = value_inc;
                end
            end else begin
                presc_cnt_d = presc_cnt_q + ONE_P;
            end
        end

        if (wr_i) begin
            case (sel_i)
                CH_TCTRL: begin
                    enable_d    = wdata_i[TCTRL_EN_BIT];
                    reload_d    = wdata_i[TCTRL_RELOAD_BIT];
                    value_d     = '0;
                    presc_cnt_d = '0;
                end
                CH_PERIOD: period_d = wdata_i[TIMER_WIDTH-1:0];
                CH_VALUE: begin
                    value_d     = wdata_i[TIMER_WIDTH-1:0];
                    presc_cnt_d = '0;
                end
                CH_PRESC: presc_d = wdata_i[PRESC_WIDTH-1:0];
                default: ;
            endcase
        end

        if (clr_i) begin
            enable_d    = 1'b0;
            reload_d    = 1'b0;
            period_d    = '0;
            value_d     = '0;
            presc_d     = '0;
            presc_cnt_d = '0;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q    <= 1'b0;
            reload_q    <= 1'b0;
            period_q    <= '0;
            value_q     <= '0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
        end else begin
            enable_q    <= enable_d;
            reload_q    <= reload_d;
            period_q    <= period_d;
            value_q     <= value_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
        end
    end

    assign enable_o      = enable_q;
    assign reload_o      = reload_q;
    assign period_o      = period_q;
    assign value_o       = value_q;
    assign presc_o       = presc_q;
    assign pending_set_o = expiry && !clr_i;

endmodule

// File: rtl/sfr_timers.sv
// Per-tile SFR block: register decode and read mux, software core reset,
// IRQ enable vector, SGI, and TSTAT/TMASK over TIMER_NUM timer channels.
module sfr_timers
    import sfr_timers_pkg::*;
#(
    parameter int unsigned CORENUM          = 0,
    parameter bit          SW_RESET_DEFAULT = 1'b0,
    parameter int unsigned IRQ_NUM_POW      = 4,
    parameter int unsigned TIMER_NUM        = 4,
    parameter int unsigned TIMER_WIDTH      = 32,
    parameter int unsigned PRESC_WIDTH      = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    MemSplit32.Slave                    host,
    input  logic                        sw_reset_enb_i,
    input  logic                        sw_reset_set_i,
    input  logic                        sw_reset_autoclr_i,
    output logic                        core_reset_o,
    output logic [(2**IRQ_NUM_POW)-1:0] irq_en_bo,
    output logic [TIMER_NUM-1:0]        timer_irq_bo,
    output logic                        irq_timer_o,
    output logic                        sgi_req_o,
    output logic [IRQ_NUM_POW-1:0]      sgi_code_bo
);

    localparam int unsigned IRQ_NUM = 2**IRQ_NUM_POW;
    localparam logic [3:0]  TN      = 4'(TIMER_NUM);

    logic                   sw_reset_q, sw_reset_d;
    logic                   autoclr_q, autoclr_d;
    logic                   core_reset_q;
    logic [IRQ_NUM-1:0]     irq_en_q, irq_en_d;
    logic                   sgi_req_q, sgi_req_d;
    logic [IRQ_NUM_POW-1:0] sgi_code_q, sgi_code_d;
    logic [TIMER_NUM-1:0]   pending_q, pending_d;
    logic [TIMER_NUM-1:0]   mask_q, mask_d;
    logic [TIMER_NUM-1:0]   timer_irq_q, timer_irq_d;
    logic                   resp_q;
    logic [31:0]            rdata_q, rdata_d;

    logic                   wr, rd;
    logic [5:0]             word;
    logic [5:0]             ch_word;
    logic [3:0]             ch_idx;
    ch_reg_e                ch_sel;
    logic                   ch_hit;
    logic                   unused_bus;

    logic                   ch_enable [TIMER_NUM];
    logic                   ch_reload [TIMER_NUM];
    logic [TIMER_WIDTH-1:0] ch_period [TIMER_NUM];
    logic [TIMER_WIDTH-1:0] ch_value  [TIMER_NUM];
    logic [PRESC_WIDTH-1:0] ch_presc  [TIMER_NUM];
    logic [TIMER_NUM-1:0]   pend_set;

    assign host.ack   = host.req;
    assign wr         = host.req && host.we;
    assign rd         = host.req && !host.we;
    assign word       = host.addr[7:2];
    assign ch_word    = word - W_CH_BASE;
    assign ch_idx     = ch_word[5:2];
    assign ch_sel     = ch_reg_e'(ch_word[1:0]);
    assign ch_hit     = (word >= W_CH_BASE) && (ch_idx < TN);
    assign unused_bus = ^{host.addr[31:8], host.addr[1:0], host.wdata};

    for (genvar k = 0; k < TIMER_NUM; k++) begin : g_ch
        sfr_timer_ch #(
            .TIMER_WIDTH(TIMER_WIDTH),
            .PRESC_WIDTH(PRESC_WIDTH)
        ) u_ch (
            .clk_i         (clk_i),
            .rst_i         (rst_i),
            .clr_i         (core_reset_q),
            .wr_i          (wr && ch_hit && (ch_idx == 4'(k))),
            .sel_i         (ch_sel),
            .wdata_i       (host.wdata),
            .enable_o      (ch_enable[k]),
            .reload_o      (ch_reload[k]),
            .period_o      (ch_period[k]),
            .value_o       (ch_value[k]),
            .presc_o       (ch_presc[k]),
            .pending_set_o (pend_set[k])
        );
    end

    // Control register next state: bus write beats the external strobe, which beats auto-clear.
    always_comb begin
        sw_reset_d = sw_reset_q;
        autoclr_d  = autoclr_q;
        irq_en_d   = irq_en_q;
        sgi_req_d  = 1'b0;
        sgi_code_d = sgi_code_q;
        pending_d  = pending_q;
        mask_d     = mask_q;

        if (wr && (word == W_CTRL)) begin
            sw_reset_d = host.wdata[0];
            autoclr_d  = host.wdata[1];
        end else if (sw_reset_enb_i) begin
            sw_reset_d = sw_reset_set_i;
            autoclr_d  = sw_reset_autoclr_i;
        end else if (sw_reset_q && autoclr_q) begin
            sw_reset_d = 1'b0;
        end

        if (wr && (word == W_IRQ_EN)) begin
            irq_en_d = host.wdata[IRQ_NUM-1:0];
        end

        if (wr && (word == W_SGI)) begin
            sgi_req_d  = 1'b1;
            sgi_code_d = host.wdata[IRQ_NUM_POW-1:0];
        end

        // A set in the same cycle as a W1C clear keeps the bit set.
        if (wr && (word == W_TSTAT)) begin
            pending_d = pending_q & ~host.wdata[TIMER_NUM-1:0];
        end
        pending_d = pending_d | pend_set;

        if (wr && (word == W_TMASK)) begin
            mask_d = host.wdata[TIMER_NUM-1:0];
        end

        if (core_reset_q) begin
            pending_d = '0;
            mask_d    = '0;
        end

        timer_irq_d = pending_d & mask_d;
    end

    // Read mux, sampled into rdata_q on the request edge; narrow fields zero-extend.
    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (word)
                W_IDCODE:    rdata_d = IDCODE;
                W_CTRL:      rdata_d = {30'd0, autoclr_q, sw_reset_q};
                W_CORENUM:   rdata_d = CORENUM;
                W_TIMER_NUM: rdata_d = TIMER_NUM;
                W_IRQ_EN:    rdata_d = 32'(irq_en_q);
                W_SGI:       rdata_d = 32'(sgi_code_q);
                W_TSTAT:     rdata_d = 32'(pending_q);
                W_TMASK:     rdata_d = 32'(mask_q);
                default: begin
                    for (int unsigned k = 0; k < TIMER_NUM; k++) begin
                        if (ch_hit && (ch_idx == 4'(k))) begin
                            case (ch_sel)
                                CH_TCTRL:  rdata_d = {30'd0, ch_reload[k], ch_enable[k]};
                                CH_PERIOD: rdata_d = 32'(ch_period[k]);
                                CH_VALUE:  rdata_d = 32'(ch_value[k]);
                                CH_PRESC:  rdata_d = 32'(ch_presc[k]);
                                default:   rdata_d = '0;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Top-level registers; core_reset_q follows sw_reset one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sw_reset_q   <= SW_RESET_DEFAULT;
            autoclr_q    <= 1'b0;
            core_reset_q <= 1'b1;
            irq_en_q     <= '0;
            sgi_req_q    <= 1'b0;
            sgi_code_q   <= '0;
            pending_q    <= '0;
            mask_q       <= '0;
            timer_irq_q  <= '0;
            resp_q       <= 1'b0;
            rdata_q      <= '0;
        end else begin
            sw_reset_q   <= sw_reset_d;
            autoclr_q    <= autoclr_d;
            core_reset_q <= sw_reset_q;
            irq_en_q     <= irq_en_d;
            sgi_req_q    <= sgi_req_d;
            sgi_code_q   <= sgi_code_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
            timer_irq_q  <= timer_irq_d;
            resp_q       <= rd;
            rdata_q      <= rdata_d;
        end
    end

    assign host.resp    = resp_q;
    assign host.rdata   = rdata_q;
    assign core_reset_o = core_reset_q;
    assign irq_en_bo    = irq_en_q;
    assign timer_irq_bo = timer_irq_q;
    assign irq_timer_o  = |timer_irq_q;
    assign sgi_req_o    = sgi_req_q;
    assign sgi_code_bo  = sgi_code_q;

endmodule

// File: tb/tb_sfr_timers.sv
// Directed bench for sfr_timers (8-bit timers, 4 channels, CORENUM=5).
module tb_sfr_timers;

    logic        clk;
    logic        rst;
    logic        sw_reset_enb;
    logic        sw_reset_set;
    logic        sw_reset_autoclr;
    logic        core_reset;
    logic [15:0] irq_en;
    logic [3:0]  timer_irq;
    logic        irq_timer;
    logic        sgi_req;
    logic [3:0]  sgi_code;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] exp_q[$];

    MemSplit32 bus();

    sfr_timers #(
        .CORENUM          (5),
        .SW_RESET_DEFAULT (1'b0),
        .IRQ_NUM_POW      (4),
        .TIMER_NUM        (4),
        .TIMER_WIDTH      (8),
        .PRESC_WIDTH      (8)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .host               (bus),
        .sw_reset_enb_i     (sw_reset_enb),
        .sw_reset_set_i     (sw_reset_set),
        .sw_reset_autoclr_i (sw_reset_autoclr),
        .core_reset_o       (core_reset),
        .irq_en_bo          (irq_en),
        .timer_irq_bo       (timer_irq),
        .irq_timer_o        (irq_timer),
        .sgi_req_o          (sgi_req),
        .sgi_code_bo        (sgi_code)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance n active edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write takes effect on the first edge; returns 1 unit after it.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = addr;
        bus.wdata = data;
        step(1);
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        check("wr_no_resp", 32'(bus.resp), 32'd0);
    endtask

    // Read sampled on the first edge; rdata/resp checked 1 unit after it.
    task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.req   = 1'b1;
        bus.we    = 1'b0;
        bus.addr  = addr;
        bus.wdata = 32'd0;
        #1;
        check({tag, "_ack"}, 32'(bus.ack), 32'd1);
        @(posedge clk);
        #1;
        check({tag, "_resp"}, 32'(bus.resp), 32'd1);
        check(tag, bus.rdata, exp_q.pop_front());
        bus.req = 1'b0;
    endtask

    initial begin
        rst              = 1'b0;
        bus.req          = 1'b0;
        bus.we           = 1'b0;
        bus.addr         = 32'd0;
        bus.wdata        = 32'd0;
        sw_reset_enb     = 1'b0;
        sw_reset_set     = 1'b0;
        sw_reset_autoclr = 1'b0;

        // Reset without any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_core_reset", 32'(core_reset), 32'd1);
        check("rst_irq_en", 32'(irq_en), 32'd0);
        check("rst_timer_irq", 32'(timer_irq), 32'd0);
        check("rst_irq_timer", 32'(irq_timer), 32'd0);
        check("rst_sgi_req", 32'(sgi_req), 32'd0);
        check("rst_sgi_code", 32'(sgi_code), 32'd0);
        check("rst_resp", 32'(bus.resp), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        step(2);
        rst = 1'b0;
        step(1);
        check("core_reset_release", 32'(core_reset), 32'd0);

        // Identification and decode
        bus_read("idcode", 32'h00, 32'hDEADBEEF);
        bus_read("corenum", 32'h08, 32'd5);
        bus_read("timer_num", 32'h0C, 32'd4);
        bus_read("ctrl_rst", 32'h04, 32'd0);
        bus_read("unmapped", 32'h20, 32'd0);
        bus_read("no_ch4", 32'h80, 32'd0);

        // Periodic ch0: PERIOD=5, PRESC=0, expiry 5 edges after the TCTRL write edge
        bus_write(32'h44, 32'd5);
        bus_write(32'h4C, 32'd0);
        bus_write(32'h1C, 32'h1);
        bus_write(32'h40, 32'h3);
        step(4);
        check("per_before", 32'(timer_irq), 32'h0);
        step(1);
        check("per_first", 32'(timer_irq), 32'h1);
        check("per_irq_timer", 32'(irq_timer), 32'd1);
        bus_write(32'h18, 32'h1);
        check("per_w1c", 32'(timer_irq), 32'h0);
        step(3);
        check("per_before2", 32'(timer_irq), 32'h0);
        step(1);
        check("per_second", 32'(timer_irq), 32'h1);
        bus_read("per_tstat", 32'h18, 32'h1);
        bus_write(32'h40, 32'h0);
        bus_write(32'h18, 32'h1);
        bus_read("per_tstat_clr", 32'h18, 32'h0);

        // One-shot ch2 with prescaler: PERIOD=3, PRESC=2 -> 9 cycles
        bus_write(32'h64, 32'd3);
        bus_write(32'h6C, 32'd2);
        bus_write(32'h1C, 32'h4);
        bus_write(32'h60, 32'h1);
        step(8);
        check("os_before", 32'(timer_irq), 32'h0);
        step(1);
        check("os_expire", 32'(timer_irq), 32'h4);
        check("os_irq_timer", 32'(irq_timer), 32'd1);
        bus_read("os_tctrl", 32'h60, 32'h0);
        bus_read("os_value", 32'h68, 32'h0);
        step(5);
        bus_read("os_value_hold", 32'h68, 32'h0);
        bus_write(32'h18, 32'h4);

        // W1C landing on the expiry edge: set wins
        bus_write(32'h54, 32'd4);
        bus_write(32'h5C, 32'd0);
        bus_write(32'h50, 32'h1);
        step(3);
        bus_write(32'h18, 32'h2);
        bus_read("w1c_vs_set", 32'h18, 32'h2);
        bus_write(32'h18, 32'h2);
        bus_read("w1c_after", 32'h18, 32'h0);

        // TCTRL write landing on the expiry edge: host keeps enable=1
        bus_write(32'h50, 32'h1);
        step(3);
        bus_write(32'h50, 32'h1);
        bus_read("tctrl_vs_exp", 32'h50, 32'h1);
        bus_read("tctrl_vs_exp_val", 32'h58, 32'h1);
        step(3);
        bus_read("tctrl_oneshot_end", 32'h50, 32'h0);
        bus_write(32'h18, 32'h2);
        bus_read("tctrl_tstat_clr", 32'h18, 32'h0);

        // PERIOD=0 on ch3: 8-bit wrap with no pending
        bus_write(32'h1C, 32'h0);
        bus_write(32'h74, 32'd0);
        bus_write(32'h7C, 32'd0);
        bus_write(32'h70, 32'h1);
        bus_write(32'h78, 32'hFD);
        step(2);
        bus_read("wrap_ff", 32'h78, 32'hFF);
        bus_read("wrap_00", 32'h78, 32'h00);
        bus_read("wrap_no_pend", 32'h18, 32'h0);

        // Expiry with mask=0: TSTAT set, no interrupt output
        bus_write(32'h74, 32'd2);
        bus_write(32'h70, 32'h1);
        step(2);
        check("mask0_timer_irq", 32'(timer_irq), 32'h0);
        check("mask0_irq_timer", 32'(irq_timer), 32'd0);
        bus_read("mask0_tstat", 32'h18, 32'h8);
        bus_write(32'h18, 32'h8);

        // Software reset with auto-clear while ch0 runs
        bus_write(32'h10, 32'hA5A5);
        bus_write(32'h1C, 32'hF);
        bus_write(32'h44, 32'd5);
        bus_write(32'h40, 32'h3);
        step(6);
        check("mid_pend", 32'(timer_irq), 32'h1);
        bus_write(32'h04, 32'h3);
        check("swr_not_yet", 32'(core_reset), 32'd0);
        step(1);
        check("swr_high", 32'(core_reset), 32'd1);
        step(1);
        check("swr_low", 32'(core_reset), 32'd0);
        check("swr_timer_irq", 32'(timer_irq), 32'h0);
        check("swr_irq_timer", 32'(irq_timer), 32'd0);
        bus_read("swr_ctrl", 32'h04, 32'h2);
        bus_read("swr_tstat", 32'h18, 32'h0);
        bus_read("swr_tmask", 32'h1C, 32'h0);
        bus_read("swr_tctrl0", 32'h40, 32'h0);
        bus_read("swr_period0", 32'h44, 32'h0);
        bus_read("swr_irq_en", 32'h10, 32'hA5A5);
        check("swr_irq_en_out", 32'(irq_en), 32'hA5A5);

        // SGI pulse
        bus_write(32'h14, 32'h7);
        check("sgi_pulse", 32'(sgi_req), 32'd1);
        check("sgi_code", 32'(sgi_code), 32'h7);
        step(1);
        check("sgi_pulse_end", 32'(sgi_req), 32'd0);
        check("sgi_code_hold", 32'(sgi_code), 32'h7);

        // External strobe without auto-clear holds core reset
        sw_reset_enb     = 1'b1;
        sw_reset_set     = 1'b1;
        sw_reset_autoclr = 1'b0;
        step(1);
        sw_reset_enb = 1'b0;
        step(1);
        check("ext_core_reset", 32'(core_reset), 32'd1);
        step(2);
        check("ext_core_reset_hold", 32'(core_reset), 32'd1);

        // CTRL write beats a same-cycle strobe
        sw_reset_enb     = 1'b1;
        sw_reset_set     = 1'b1;
        sw_reset_autoclr = 1'b1;
        bus_write(32'h04, 32'h0);
        sw_reset_enb = 1'b0;
        bus_read("ctrl_priority", 32'h04, 32'h0);
        check("ctrl_priority_rst", 32'(core_reset), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
